ps2_rx: RTL and testbench
=========================

Name: ps2_rx

Overview:
PS/2 device-to-host receiver, the companion of ps2_tx in the keyboard/mouse input path of the falling-sand game.
- Samples the open-collector ps2c/ps2d lines and deserialises the 11-bit frame: start, 8 data bits LSB first, odd parity, stop.
- Presents the scan code with a one-cycle done strobe plus error flags.
- rx_en_i lets the PS/2 top level mute reception while ps2_tx owns the bus.

Parameters:
FILTER_LEN, 8, consecutive identical synchronised ps2c samples required before the filtered clock changes level.
TIMEOUT_CYCLES, 20000, clk_i cycles allowed between filtered ps2c falling edges mid-frame before abort (200 us at 100 MHz).

Ports:
clk_i  input  1  system clock, 100 MHz nominal.
reset_i  input  1  asynchronous, active-low reset.
rx_en_i  input  1  receive enable; low forces IDLE, and frames are only started while high.
ps2c_i  input  1  raw PS/2 clock from the pad, asynchronous.
ps2d_i  input  1  raw PS/2 data from the pad, asynchronous.
rx_data_o  output  8  last received byte; held until the next done.
rx_done_o  output  1  one-cycle strobe, frame complete.
parity_err_o  output  1  parity status of the last completed frame; valid with and after rx_done_o.
frame_err_o  output  1  one-cycle strobe: bad stop bit or timeout abort.
idle_o  output  1  high in IDLE.

Behaviour:
- Reset (reset_i low, asynchronous):
  - rx_data_o=0, rx_done_o=0, parity_err_o=0, frame_err_o=0, idle_o=1, state=IDLE.
  - Synchroniser flops and filtered clock reset to 1; shift register and counters reset to 0.
- Input conditioning:
  - Two-flop synchroniser on each of ps2c_i and ps2d_i.
  - Filtered clock changes level only after FILTER_LEN consecutive equal synchronised samples that differ from it.
  - fall = one-cycle pulse when the filtered clock goes 1->0.
  - ps2d is sampled from the synchroniser output in the fall cycle.
  - Latency from a pad edge to fall: 2 + FILTER_LEN cycles.
- FSM, states IDLE, RX, DONE:
  - IDLE: on fall with rx_en_i=1 and sampled data=0 (start bit), go to RX with bit_cnt=0 and timer cleared. A fall with data=1 is ignored (spurious), and the FSM stays in IDLE.
  - RX: each fall shifts the sampled bit into a 10-bit shift register from the MSB end, clears the timer, and increments bit_cnt. When the 10th bit after start (the stop bit) arrives, go to DONE.
  - RX timer: increments every cycle without fall. On reaching TIMEOUT_CYCLES, pulse frame_err_o and return to IDLE; rx_data_o and parity_err_o are unchanged.
  - rx_en_i low in RX: return to IDLE the next cycle with no strobes.
  - DONE, one cycle, then always IDLE:
    - If stop=1: rx_data_o <= data bits, parity_err_o <= (XOR of 8 data bits and parity bit) == 0, rx_done_o=1.
    - If stop=0: frame_err_o=1, no rx_done_o, rx_data_o and parity_err_o unchanged.
- rx_done_o and frame_err_o are never high in the same cycle.
- A fall in the DONE cycle is ignored; the PS/2 inter-frame gap makes this benign.
- idle_o = (state==IDLE), combinational from the state register.
- Reset asserted mid-frame discards the partial frame; no strobe is issued.

Decomposition:
- ps2_pkg:
  - typedef enum logic [1:0] {IDLE, RX, DONE} ps2_rx_state_t
  - localparam PS2_FRAME_BITS = 11
  - localparam PS2_DATA_BITS = 8
  - The parity helper function also lives here, to be shared with ps2_tx.
- Sub-module ps2_filter(clk_i, reset_i, ps2c_i, ps2d_i, ps2c_o, ps2d_o, fall_o), parameter FILTER_LEN. It contains the synchronisers, the debounce counter and edge detection, and is reusable by ps2_tx.

Test Plan:
- Bench device model: ps2c period 80 us (8000 cycles), data changed 20 us after each rising edge.
- Reset: release reset_i after 3 cycles -> idle_o=1, rx_data_o=0x00, no strobes, all outputs stable for 100 cycles.
- Good frame 0x1C (parity bit 0, since three ones): send start 0, 0,0,1,1,1,0,0,0, parity 0, stop 1 -> exactly one rx_done_o within 2+FILTER_LEN+2 cycles of the last ps2c fall; rx_data_o=0x1C, parity_err_o=0, frame_err_o never high.
- Back-to-back frames 0xF0 then 0x1C, 100 us gap -> two rx_done_o pulses; rx_data_o=0xF0 then 0x1C; idle_o high between frames.
- Parity error: 0x1C with parity bit 1 -> rx_done_o=1, rx_data_o=0x1C, parity_err_o=1. A following good 0x29 clears parity_err_o to 0.
- Stop error and timeout:
  - 0x1C with stop=0 -> frame_err_o pulse, no rx_done_o, rx_data_o unchanged.
  - Stop ps2c after 5 bits -> frame_err_o exactly TIMEOUT_CYCLES cycles after the last fall, then idle_o=1.
- Glitch and enable:
  - 5-cycle low pulse on ps2c_i in IDLE -> no state change.
  - Drop rx_en_i mid-frame -> IDLE next cycle, no strobes.
  - Frame sent while rx_en_i=0 -> ignored.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions for the receive and transmit paths of the input block.
// The odd-parity helper gives the parity bit that makes data plus parity carry an odd count of ones.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RX   = 2'd1,
        DONE = 2'd2
    } ps2_rx_state_t;

    localparam int PS2_FRAME_BITS = 11;
    localparam int PS2_DATA_BITS  = 8;

    function automatic logic ps2_odd_parity(input logic [PS2_DATA_BITS-1:0] data);
        return ~(^data);
    endfunction

endpackage

// File: rtl/ps2_filter.sv
// Conditions the raw PS/2 pad lines: two-flop synchronisers, a debounce on the clock line
// and a registered pulse on each filtered clock falling edge.
module ps2_filter
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 8
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic ps2c_i,
    input  logic ps2d_i,
    output logic ps2c_o,
    output logic ps2d_o,
    output logic fall_o
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    c_sync_r;
    logic [1:0]    d_sync_r;
    logic          filt_r;
    logic [CW-1:0] cnt_r;
    logic          fall_r;

    // Synchronise both lines and move the filtered clock only after a stable run of differing samples.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            c_sync_r <= 2'b11;
            d_sync_r <= 2'b11;
            filt_r   <= 1'b1;
            cnt_r    <= {CW{1'b0}};
            fall_r   <= 1'b0;
        end else begin
            c_sync_r <= {c_sync_r[0], ps2c_i};
            d_sync_r <= {d_sync_r[0], ps2d_i};
            fall_r   <= 1'b0;
            if (c_sync_r[1] == filt_r) begin
                cnt_r <= {CW{1'b0}};
            end else if (cnt_r == CW'(FILTER_LEN - 1)) begin
                // The FILTER_LEN-th differing sample commits the new level.
                filt_r <= c_sync_r[1];
                cnt_r  <= {CW{1'b0}};
                fall_r <= ~c_sync_r[1];
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
        end
    end

    assign ps2c_o = filt_r;
    assign ps2d_o = d_sync_r[1];
    assign fall_o = fall_r;

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: deserialises start, 8 data bits LSB first, odd parity and stop,
// then reports the byte with a done strobe, a parity status and a framing/timeout strobe.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       rx_en_i,
    input  logic       ps2c_i,
    input  logic       ps2d_i,
    output logic [7:0] rx_data_o,
    output logic       rx_done_o,
    output logic       parity_err_o,
    output logic       frame_err_o,
    output logic       idle_o
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SW = PS2_FRAME_BITS - 1;

    logic c_filt_s;
    logic d_s;
    logic fall_s;
    logic sample_s;

    ps2_rx_state_t     state_r,  state_nxt_s;
    logic [3:0]        bit_cnt_r, bit_cnt_nxt_s;
    logic [SW-1:0]     shift_r,  shift_nxt_s;
    logic [TW-1:0]     timer_r,  timer_nxt_s;
    logic [7:0]        rx_data_r, rx_data_nxt_s;
    logic              perr_r,   perr_nxt_s;
    logic              done_r,   done_nxt_s;
    logic              ferr_r,   ferr_nxt_s;

    ps2_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filter (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .ps2c_i  (ps2c_i),
        .ps2d_i  (ps2d_i),
        .ps2c_o  (c_filt_s),
        .ps2d_o  (d_s),
        .fall_o  (fall_s)
    );

    // Qualify the edge pulse with the filtered level it leaves behind.
    assign sample_s = fall_s & ~c_filt_s;

    // Next-state and next-output logic for the frame FSM.
    always_comb begin
        state_nxt_s   = state_r;
        bit_cnt_nxt_s = bit_cnt_r;
        shift_nxt_s   = shift_r;
        timer_nxt_s   = timer_r;
        rx_data_nxt_s = rx_data_r;
        perr_nxt_s    = perr_r;
        done_nxt_s    = 1'b0;
        ferr_nxt_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (rx_en_i && sample_s && !d_s) begin
                    state_nxt_s   = RX;
                    bit_cnt_nxt_s = 4'd0;
                    timer_nxt_s   = {TW{1'b0}};
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RX: begin
                if (!rx_en_i) begin
                    state_nxt_s = IDLE;
                end else if (sample_s) begin
                    shift_nxt_s   = {d_s, shift_r[SW-1:1]};
                    timer_nxt_s   = {TW{1'b0}};
                    bit_cnt_nxt_s = bit_cnt_r + 4'd1;
                    if (bit_cnt_r == 4'(PS2_FRAME_BITS - 2)) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = RX;
                    end
                end else if (timer_r == TW'(TIMEOUT_CYCLES - 2)) begin
                    // Timer restarts the cycle after the fall, so this lands the strobe
                    // exactly TIMEOUT_CYCLES cycles after the fall pulse.
                    ferr_nxt_s  = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    timer_nxt_s = timer_r + TW'(1);
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
                if (shift_r[SW-1]) begin
                    rx_data_nxt_s = shift_r[7:0];
                    perr_nxt_s    = (shift_r[8] != ps2_odd_parity(shift_r[7:0]));
                    done_nxt_s    = 1'b1;
                end else begin
                    ferr_nxt_s = 1'b1;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, datapath and registered output updates.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_r   <= IDLE;
            bit_cnt_r <= 4'd0;
            shift_r   <= {SW{1'b0}};
            timer_r   <= {TW{1'b0}};
            rx_data_r <= 8'h00;
            perr_r    <= 1'b0;
            done_r    <= 1'b0;
            ferr_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            bit_cnt_r <= bit_cnt_nxt_s;
            shift_r   <= shift_nxt_s;
            timer_r   <= timer_nxt_s;
            rx_data_r <= rx_data_nxt_s;
            perr_r    <= perr_nxt_s;
            done_r    <= done_nxt_s;
            ferr_r    <= ferr_nxt_s;
        end
    end

    assign rx_data_o    = rx_data_r;
    assign rx_done_o    = done_r;
    assign parity_err_o = perr_r;
    assign frame_err_o  = ferr_r;
    assign idle_o       = (state_r == IDLE);

endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: a PS/2 device model drives frames, expected results are queued per
// frame and compared when the receiver strobes. Device timing is scaled to 1 us per clk cycle.
module tb_ps2_rx;
    import ps2_pkg::*;

    localparam int FL  = 8;
    localparam int TO  = 300;
    localparam int GAP = 100;

    logic       clk = 1'b0;
    logic       reset_i = 1'b0;
    logic       rx_en_i = 1'b1;
    logic       ps2c_i = 1'b1;
    logic       ps2d_i = 1'b1;
    logic [7:0] rx_data_o;
    logic       rx_done_o;
    logic       parity_err_o;
    logic       frame_err_o;
    logic       idle_o;

    ps2_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .rx_en_i      (rx_en_i),
        .ps2c_i       (ps2c_i),
        .ps2d_i       (ps2d_i),
        .rx_data_o    (rx_data_o),
        .rx_done_o    (rx_done_o),
        .parity_err_o (parity_err_o),
        .frame_err_o  (frame_err_o),
        .idle_o       (idle_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: capture every strobe on the falling edge.
    int         n_strobes = 0, n_done = 0, n_ferr = 0, both_cnt = 0, last_cyc = 0;
    logic [7:0] last_data = 8'h00;
    logic       last_perr = 1'b0, last_kind = 1'b0;
    always @(negedge clk) begin
        if (reset_i && (rx_done_o || frame_err_o)) begin
            n_strobes <= n_strobes + 1;
            n_done    <= n_done + (rx_done_o ? 1 : 0);
            n_ferr    <= n_ferr + (frame_err_o ? 1 : 0);
            last_data <= rx_data_o;
            last_perr <= parity_err_o;
            last_kind <= frame_err_o;
            last_cyc  <= cyc;
            if (rx_done_o && frame_err_o) both_cnt <= both_cnt + 1;
        end
    end

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;
    exp_t sb[$];

    int         total = 0, passed = 0, seen = 0, last_fall = 0;
    logic [7:0] held_data = 8'h00;
    logic       held_perr = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic bad_par, input logic stop);
        return {stop, ps2_odd_parity(d) ^ bad_par, d, 1'b0};
    endfunction

    // Device model: 80-cycle clock period, data changes 20 cycles after each rising edge.
    task automatic send_bits(input logic [10:0] f, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            ps2d_i = f[i];
            tick(20);
            ps2c_i    = 1'b0;
            last_fall = cyc;
            tick(40);
            ps2c_i = 1'b1;
            tick(20);
        end
        ps2d_i = 1'b1;
    endtask

    task automatic push_done(input logic [7:0] d, input logic perr);
        sb.push_back('{data: d, perr: perr, ferr: 1'b0});
        held_data = d;
        held_perr = perr;
    endtask

    task automatic push_ferr();
        sb.push_back('{data: held_data, perr: held_perr, ferr: 1'b1});
    endtask

    task automatic expect_strobe(input string tag, input int budget);
        int   k = 0;
        exp_t e;
        while (n_strobes <= seen && k < budget) begin
            tick(1);
            k++;
        end
        check({tag, "_arrive"}, n_strobes, seen + 1);
        if (n_strobes > seen && sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_kind"}, last_kind, e.ferr);
            check({tag, "_data"}, last_data, e.data);
            check({tag, "_perr"}, last_perr, e.perr);
        end
        seen = n_strobes;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int bad;
        tick(3);
        check("rst_idle", idle_o, 1);
        check("rst_data", rx_data_o, 8'h00);
        check("rst_strobes", {rx_done_o, frame_err_o, parity_err_o}, 3'b000);
        reset_i = 1'b1;
        bad = 0;
        repeat (100) begin
            tick(1);
            if (idle_o !== 1'b1 || rx_data_o !== 8'h00 || rx_done_o !== 1'b0 ||
                parity_err_o !== 1'b0 || frame_err_o !== 1'b0) bad++;
        end
        check("rst_stable", bad, 0);

        push_done(8'h1C, 1'b0);
        send_bits(mk_frame(8'h1C, 1'b0, 1'b1), 11);
        expect_strobe("good1c", 50);
        check("good1c_latency", (last_cyc - last_fall) <= (2 + FL + 2), 1);
        check("good1c_no_ferr", n_ferr, 0);

        push_done(8'hF0, 1'b0);
        send_bits(mk_frame(8'hF0, 1'b0, 1'b1), 11);
        tick(GAP);
        check("b2b_idle_gap", idle_o, 1);
        expect_strobe("b2b_f0", 50);
        push_done(8'h1C, 1'b0);
        send_bits(mk_frame(8'h1C, 1'b0, 1'b1), 11);
        expect_strobe("b2b_1c", 50);

        push_done(8'h1C, 1'b1);
        send_bits(mk_frame(8'h1C, 1'b1, 1'b1), 11);
        expect_strobe("par_err", 50);
        push_done(8'h29, 1'b0);
        send_bits(mk_frame(8'h29, 1'b0, 1'b1), 11);
        expect_strobe("par_clear", 50);
        check("par_clear_out", parity_err_o, 0);

        push_ferr();
        send_bits(mk_frame(8'h1C, 1'b0, 1'b0), 11);
        expect_strobe("stop_err", 50);
        check("stop_err_data_held", rx_data_o, 8'h29);

        push_ferr();
        send_bits(mk_frame(8'hA5, 1'b0, 1'b1), 5);
        expect_strobe("timeout", TO + 100);
        check("timeout_cycle", last_cyc - last_fall, 2 + FL + TO);
        check("timeout_idle", idle_o, 1);

        ps2c_i = 1'b0;
        tick(5);
        ps2c_i = 1'b1;
        bad = 0;
        repeat (40) begin
            tick(1);
            if (idle_o !== 1'b1) bad++;
        end
        check("glitch_idle", bad, 0);
        check("glitch_no_strobe", n_strobes, seen);

        send_bits(mk_frame(8'h5A, 1'b0, 1'b1), 4);
        check("en_drop_in_rx", idle_o, 0);
        rx_en_i = 1'b0;
        tick(1);
        check("en_drop_idle", idle_o, 1);
        tick(TO + 50);
        check("en_drop_no_strobe", n_strobes, seen);

        send_bits(mk_frame(8'h33, 1'b0, 1'b1), 11);
        tick(50);
        check("en_off_no_strobe", n_strobes, seen);
        check("en_off_data_held", rx_data_o, 8'h29);
        rx_en_i = 1'b1;

        check("total_done", n_done, 5);
        check("total_ferr", n_ferr, 2);
        check("never_both", both_cnt, 0);
        check("sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
